dbus_responder: RTL and testbench

Slave/responder end of the processor data bus: it answers the core's load/store strobes with word-addressed RAM and a small MMIO register block. The MMIO block provides a console TX FIFO, a 64-bit cycle counter and a simulation exit register. It sits beside the processor top, wired directly to its dataBus* pins. Load data returns one cycle after the request, so it lands in the core's WB stage.

---
 rtl/loopyV_data_types.sv | 46 ++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/dbus_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_dbus_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loopyV_data_types.sv
`default_nettype none
// ============================================================================
// Module      : loopyV_data_types (package)
// Description : Shared types and constants for the data-bus responder:
//               MMIO register offsets, console status bit positions,
//               address-region enum and the region decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package loopyV_data_types;

    // MMIO register offsets inside the 16-byte window
    localparam logic [3:0] CON_OFF    = 4'h0;
    localparam logic [3:0] CYC_LO_OFF = 4'h4;
    localparam logic [3:0] CYC_HI_OFF = 4'h8;
    localparam logic [3:0] EXIT_OFF   = 4'hC;

    // Bit positions in the CON status word
    localparam int CON_EMPTY_BIT = 0;
    localparam int CON_FULL_BIT  = 1;
    localparam int CON_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_t;

    // Range compares are done in 33 bits so a window that ends exactly at
    // 2^32 does not wrap into a false miss.
    function automatic region_t decodeRegion(
        input logic [31:0] addr,
        input logic [31:0] ramBase,
        input logic [32:0] ramBytes,
        input logic [31:0] mmioBase
    );
        logic [32:0] a;
        a = {1'b0, addr};
        if ((a >= {1'b0, ramBase}) && (a < ({1'b0, ramBase} + ramBytes)))
            return REG_RAM;
        if ((a >= {1'b0, mmioBase}) && (a < ({1'b0, mmioBase} + 33'd16)))
            return REG_MMIO;
        return REG_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO. Pointers carry one extra MSB so full and
//               empty are distinguished without a counter. Push and pop may
//               happen together at any occupancy, including full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wrPtr;
    logic [c_AW:0]    r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign empty    = (r_wrPtr == r_rdPtr);
    assign full     = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                      (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
    assign w_doPop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves the same cycle
    assign w_doPush = push && (!full || w_doPop);
    assign headData = r_mem[r_rdPtr[c_AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[c_AW-1:0]] <= pushData;
    end

endmodule
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : dbus_responder
// Description : Data-bus slave for the core. Word-addressed RAM plus a small
//               MMIO block (console TX FIFO, 64-bit cycle counter with
//               high-word snapshot, simulation exit register). Load data is
//               registered and appears the cycle after the request.
//               Optional build macro: DBUS_ACCESS_ERR_EN adds the busErr
//               output flagging unmapped and misaligned full-word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_responder
    import loopyV_data_types::*;
#(
    parameter int          RAM_WORDS      = 4096,
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
    parameter int          CON_FIFO_DEPTH = 8,
    // Counter value loaded at reset; nonzero only for bring-up of wrap paths
    parameter logic [63:0] CYC_RESET      = 64'd0
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [31:0] dataBusAddr,
    input  logic [31:0] dataBusStData,
    input  logic        dataBusLdSignal,
    input  logic        dataBusStSignal,
    input  logic [3:0]  dataBusWriteMask,
    output logic [31:0] dataBusLdData,
    output logic        conValid,
    output logic [7:0]  conData,
    input  logic        conReady,
    output logic        simDone,
    output logic [31:0] simExitCode
`ifdef DBUS_ACCESS_ERR_EN
    ,
    output logic        busErr
`endif
);

    localparam int          c_RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [32:0] c_RAM_BYTES = 33'(RAM_WORDS) << 2;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    region_t             w_region;
    logic [c_RAM_AW-1:0] w_ramIdx;
    logic [3:0]          w_mmioOff;
    logic                w_access;
    logic                w_err;
    logic                w_ok;

    assign w_region  = decodeRegion(dataBusAddr, RAM_BASE, c_RAM_BYTES, MMIO_BASE);
    // Low-order subtraction is exact inside each window
    assign w_ramIdx  = dataBusAddr[c_RAM_AW+1:2] - RAM_BASE[c_RAM_AW+1:2];
    assign w_mmioOff = {dataBusAddr[3:2] - MMIO_BASE[3:2], 2'b00};
    assign w_access  = dataBusLdSignal || dataBusStSignal;

`ifdef DBUS_ACCESS_ERR_EN
    assign w_err = w_access &&
                   ((w_region == REG_NONE) ||
                    ((dataBusAddr[1:0] != 2'b00) && (dataBusWriteMask == 4'hF)));
`else
    assign w_err = 1'b0;
`endif
    assign w_ok = !w_err;

    // ------------------------------------------------------------------
    // Qualified strobes
    // ------------------------------------------------------------------
    logic w_ramWe;
    logic w_mmioWe;
    logic w_mmioRd;
    logic w_conPush;
    logic w_conPop;
    logic w_conRd;
    logic w_cycLoRd;
    logic w_exitWe;

    assign w_ramWe   = dataBusStSignal && (w_region == REG_RAM) && w_ok;
    assign w_mmioWe  = dataBusStSignal && (w_region == REG_MMIO) && w_ok &&
                       (dataBusWriteMask != 4'h0);
    assign w_mmioRd  = dataBusLdSignal && (w_region == REG_MMIO) && w_ok;
    assign w_conPush = w_mmioWe && (w_mmioOff == CON_OFF);
    assign w_exitWe  = w_mmioWe && (w_mmioOff == EXIT_OFF);
    assign w_conRd   = w_mmioRd && (w_mmioOff == CON_OFF);
    assign w_cycLoRd = w_mmioRd && (w_mmioOff == CYC_LO_OFF);

    // ------------------------------------------------------------------
    // RAM: asynchronous read of the old word gives read-before-write
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] w_ramRdData;

    assign w_ramRdData = r_ram[w_ramIdx];

    // Byte-masked RAM write
    always_ff @(posedge clk) begin
        if (w_ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (dataBusWriteMask[b])
                    r_ram[w_ramIdx][8*b +: 8] <= dataBusStData[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic       w_fifoFull;
    logic       w_fifoEmpty;
    logic [7:0] w_fifoHead;
    logic       r_conOvf;
    logic       w_pushDrop;

    assign conValid   = !w_fifoEmpty;
    assign w_conPop   = conValid && conReady;
    // Head storage is not reset, so hide it while empty
    assign conData    = w_fifoEmpty ? 8'h00 : w_fifoHead;
    assign w_pushDrop = w_conPush && w_fifoFull && !w_conPop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_FIFO_DEPTH)
    ) u_conFifo (
        .clk      (clk),
        .arstn    (arstn),
        .push     (w_conPush),
        .pushData (dataBusStData[7:0]),
        .pop      (w_conPop),
        .headData (w_fifoHead),
        .full     (w_fifoFull),
        .empty    (w_fifoEmpty)
    );

    // Sticky overflow; a same-cycle dropped push wins over the read-clear
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)          r_conOvf <= 1'b0;
        else if (w_pushDrop) r_conOvf <= 1'b1;
        else if (w_conRd)    r_conOvf <= 1'b0;
    end

    // ------------------------------------------------------------------
    // Cycle counter and high-word snapshot
    // ------------------------------------------------------------------
    logic [63:0] r_cycCnt;
    logic [31:0] r_cycSnap;

    // Free-running counter, wraps at 2^64
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_cycCnt <= CYC_RESET;
        else        r_cycCnt <= r_cycCnt + 64'd1;
    end

    // Capture the upper word whenever the low word is read
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)         r_cycSnap <= 32'h0;
        else if (w_cycLoRd) r_cycSnap <= r_cycCnt[63:32];
    end

    // ------------------------------------------------------------------
    // Exit register
    // ------------------------------------------------------------------
    logic        r_simDone;
    logic [31:0] r_exitCode;

    assign simDone     = r_simDone;
    assign simExitCode = r_exitCode;

    // Any EXIT write records the code; done stays set until reset
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_simDone  <= 1'b0;
            r_exitCode <= 32'h0;
        end else if (w_exitWe) begin
            r_simDone  <= 1'b1;
            r_exitCode <= dataBusStData;
        end
    end

    // ------------------------------------------------------------------
    // Load data select; all sources are pre-update values this cycle
    // ------------------------------------------------------------------
    logic [31:0] w_mmioRdData;
    logic [31:0] w_ldNext;
    logic [31:0] r_ldData;

    // MMIO read mux
    always_comb begin
        w_mmioRdData = 32'h0;
        case (w_mmioOff)
            CON_OFF: begin
                w_mmioRdData[CON_EMPTY_BIT] = w_fifoEmpty;
                w_mmioRdData[CON_FULL_BIT]  = w_fifoFull;
                w_mmioRdData[CON_OVF_BIT]   = r_conOvf;
            end
            CYC_LO_OFF: w_mmioRdData = r_cycCnt[31:0];
            CYC_HI_OFF: w_mmioRdData = r_cycSnap;
            EXIT_OFF:   w_mmioRdData = r_exitCode;
            default:    w_mmioRdData = 32'h0;
        endcase
    end

    // Region select; flagged or unmapped loads return zero
    always_comb begin
        w_ldNext = 32'h0;
        if (w_ok) begin
            case (w_region)
                REG_RAM:  w_ldNext = w_ramRdData;
                REG_MMIO: w_ldNext = w_mmioRdData;
                default:  w_ldNext = 32'h0;
            endcase
        end
    end

    // Load data register holds until the next load
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)               r_ldData <= 32'h0;
        else if (dataBusLdSignal) r_ldData <= w_ldNext;
    end

    assign dataBusLdData = r_ldData;

`ifdef DBUS_ACCESS_ERR_EN
    logic r_busErr;

    // One-cycle error pulse aligned with the load data
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_busErr <= 1'b0;
        else        r_busErr <= w_err;
    end

    assign busErr = r_busErr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_responder
// Description : Self-checking bench for dbus_responder: table-driven RAM
//               vectors, load scoreboard, console, counter, exit and reset
//               sequences. Covers busErr when DBUS_ACCESS_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_responder;

    localparam int          RAM_WORDS      = 4096;
    localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE      = 32'h8000_0000;
    localparam int          CON_FIFO_DEPTH = 8;
    localparam logic [63:0] CYC_RESET      = 64'h0000_0000_FFFF_FFC0;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [31:0] dataBusAddr = '0;
    logic [31:0] dataBusStData = '0;
    logic        dataBusLdSignal = 1'b0;
    logic        dataBusStSignal = 1'b0;
    logic [3:0]  dataBusWriteMask = '0;
    logic [31:0] dataBusLdData;
    logic        conValid;
    logic [7:0]  conData;
    logic        conReady = 1'b0;
    logic        simDone;
    logic [31:0] simExitCode;
`ifdef DBUS_ACCESS_ERR_EN
    logic        busErr;
`endif

    dbus_responder #(
        .RAM_WORDS      (RAM_WORDS),
        .RAM_BASE       (RAM_BASE),
        .MMIO_BASE      (MMIO_BASE),
        .CON_FIFO_DEPTH (CON_FIFO_DEPTH),
        .CYC_RESET      (CYC_RESET)
    ) dut (
        .clk              (clk),
        .arstn            (arstn),
        .dataBusAddr      (dataBusAddr),
        .dataBusStData    (dataBusStData),
        .dataBusLdSignal  (dataBusLdSignal),
        .dataBusStSignal  (dataBusStSignal),
        .dataBusWriteMask (dataBusWriteMask),
        .dataBusLdData    (dataBusLdData),
        .conValid         (conValid),
        .conData          (conData),
        .conReady         (conReady),
        .simDone          (simDone),
        .simExitCode      (simExitCode)
`ifdef DBUS_ACCESS_ERR_EN
        ,
        .busErr           (busErr)
`endif
    );

    always #5 clk = ~clk;

    int          nCmp = 0;
    int          nErr = 0;
    int          edgeCnt = 0;
    logic [31:0] ldQ [$];
    logic [7:0]  conQ [$];

    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] expLd;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edgeCnt++;
    endtask

    function automatic bit isUnmapped(input logic [31:0] a);
        bit inRam;
        bit inMmio;
        inRam  = (a < 32'(RAM_WORDS * 4));
        inMmio = (a >= MMIO_BASE) && (a <= MMIO_BASE + 32'd15);
        return !(inRam || inMmio);
    endfunction

    // One bus cycle; expected load data goes through the scoreboard queue
    task automatic access(input bit ld, input bit st, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask,
                          input logic [31:0] expLd, input string name);
        logic [31:0] e;
        bit          expErr;
        dataBusAddr      = addr;
        dataBusStData    = data;
        dataBusWriteMask = mask;
        dataBusLdSignal  = ld;
        dataBusStSignal  = st;
        expErr = (ld || st) && (isUnmapped(addr) || ((addr[1:0] != 2'b00) && (mask == 4'hF)));
        if (ld) ldQ.push_back(expLd);
        tick();
        dataBusLdSignal = 1'b0;
        dataBusStSignal = 1'b0;
        if (ld) begin
            e = ldQ.pop_front();
            check(name, {32'h0, dataBusLdData}, {32'h0, e});
        end
`ifdef DBUS_ACCESS_ERR_EN
        check({name, "_err"}, {63'h0, busErr}, {63'h0, expErr});
`else
        if (expErr) begin end
`endif
    endtask

    initial begin
        logic [63:0] cExp;
        logic [31:0] hiExp;
        int          budget;
        int          popped;

        // RAM vectors: {ld, st, addr, data, mask, expected load}
        vt[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEAA};
        vt[4]  = '{1'b0, 1'b1, 32'h20,   32'h0,        4'hF, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 32'h20,   32'h0,        4'hF, 32'h11223344};
        vt[7]  = '{1'b0, 1'b1, 32'h30,   32'hCAFEF00D, 4'hF, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 32'h30,   32'hFFFFFFFF, 4'h0, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 32'h30,   32'h00AABB00, 4'h6, 32'h0};
        vt[10] = '{1'b1, 1'b0, 32'h30,   32'h0,        4'hF, 32'hCAAABB0D};
        vt[11] = '{1'b0, 1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0};
        vt[12] = '{1'b0, 1'b1, 32'h4000, 32'h55555555, 4'hF, 32'h0};
        vt[13] = '{1'b1, 1'b0, 32'h0,    32'h0,        4'hF, 32'h01020304};
        vt[14] = '{1'b1, 1'b0, 32'h4000, 32'h0,        4'hF, 32'h0};

        // Reset state
        #12;
        check("rst_ldData",  {32'h0, dataBusLdData}, 64'h0);
        check("rst_conValid", {63'h0, conValid},     64'h0);
        check("rst_conData",  {56'h0, conData},      64'h0);
        check("rst_simDone",  {63'h0, simDone},      64'h0);
        check("rst_exitCode", {32'h0, simExitCode},  64'h0);
`ifdef DBUS_ACCESS_ERR_EN
        check("rst_busErr",   {63'h0, busErr},       64'h0);
`endif
        @(posedge clk);
        #1;
        arstn   = 1'b1;
        edgeCnt = 0;

        // Counter: low read before the 32-bit wrap, high read after it
        cExp = CYC_RESET + 64'(edgeCnt);
        access(1, 0, MMIO_BASE + 32'h4, 32'h0, 4'hF, cExp[31:0], "cyc_lo_pre");
        hiExp = cExp[63:32];
        repeat (80) tick();
        access(1, 0, MMIO_BASE + 32'h8, 32'h0, 4'hF, hiExp, "cyc_hi_snap");
        cExp = CYC_RESET + 64'(edgeCnt);
        access(1, 0, MMIO_BASE + 32'h4, 32'h0, 4'hF, cExp[31:0], "cyc_lo_post");
        hiExp = cExp[63:32];
        access(0, 1, MMIO_BASE + 32'h8, 32'hFFFFFFFF, 4'hF, 32'h0, "cyc_hi_wr");
        access(1, 0, MMIO_BASE + 32'h8, 32'h0, 4'hF, hiExp, "cyc_hi_wrap");

        // Table-driven RAM vectors
        for (int i = 0; i < 15; i++)
            access(vt[i].ld, vt[i].st, vt[i].addr, vt[i].data, vt[i].mask,
                   vt[i].expLd, $sformatf("vec%0d", i));

        // Console: nine pushes into depth 8 with the sink stalled
        conReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            access(0, 1, MMIO_BASE, {24'h0, 8'(8'h41 + i)}, 4'h1, 32'h0, "con_push");
            if (i < CON_FIFO_DEPTH) conQ.push_back(8'(8'h41 + i));
        end
        access(1, 0, MMIO_BASE, 32'h0, 4'hF, 32'h6, "con_stat_ovf");
        access(1, 0, MMIO_BASE, 32'h0, 4'hF, 32'h2, "con_stat_clr");
        check("con_head_valid", {63'h0, conValid}, 64'h1);

        conReady = 1'b1;
        budget   = 20;
        popped   = 0;
        while (conValid && budget > 0) begin
            if (conQ.size() > 0) check("con_data", {56'h0, conData}, {56'h0, conQ.pop_front()});
            popped++;
            budget--;
            tick();
        end
        check("con_pop_count", 64'(popped), 64'(CON_FIFO_DEPTH));
        check("con_drained", {63'h0, conValid}, 64'h0);
        conReady = 1'b0;
        access(1, 0, MMIO_BASE, 32'h0, 4'hF, 32'h1, "con_stat_empty");

        // Exit register
        access(1, 0, MMIO_BASE + 32'hC, 32'h0, 4'hF, 32'h0, "exit_rd0");
        check("simDone_pre", {63'h0, simDone}, 64'h0);
        access(0, 1, MMIO_BASE + 32'hC, 32'h2A, 4'hF, 32'h0, "exit_wr");
        check("simDone", {63'h0, simDone}, 64'h1);
        check("exitCode", {32'h0, simExitCode}, 64'h2A);
        access(1, 0, MMIO_BASE + 32'hC, 32'h0, 4'hF, 32'h2A, "exit_rd");
        access(0, 1, MMIO_BASE + 32'hC, 32'h7, 4'hF, 32'h0, "exit_wr2");
        check("exitCode2", {32'h0, simExitCode}, 64'h7);
        check("simDone_sticky", {63'h0, simDone}, 64'h1);

`ifdef DBUS_ACCESS_ERR_EN
        access(1, 0, 32'h4000_0000, 32'h0, 4'hF, 32'h0, "err_unmapped_ld");
        tick();
        check("err_pulse_end", {63'h0, busErr}, 64'h0);
        access(0, 1, 32'h12, 32'h99999999, 4'hF, 32'h0, "err_misaligned_st");
        access(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, "err_ram_kept");
`endif

        // Asynchronous reset mid-run; ldData currently holds a nonzero value
        conReady = 1'b0;
        access(0, 1, MMIO_BASE, 32'h5A, 4'h1, 32'h0, "con_push_pre_rst");
        #2;
        arstn = 1'b0;
        #1;
        check("arst_ldData",   {32'h0, dataBusLdData}, 64'h0);
        check("arst_conValid", {63'h0, conValid},      64'h0);
        check("arst_conData",  {56'h0, conData},       64'h0);
        check("arst_simDone",  {63'h0, simDone},       64'h0);
        check("arst_exitCode", {32'h0, simExitCode},   64'h0);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        access(1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, "ram_survives_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
